// File: rtl/data_mem_arbiter_pkg.sv
// data_mem_arbiter_pkg: shared state encoding, requester indices and default widths
package data_mem_arbiter_pkg;
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 16;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
    localparam logic REQ_CORE = 1'b0;
    localparam logic REQ_HOST = 1'b1;
    typedef enum logic [1:0] {
        ST_IDLE = IDLE,
        ST_ISSUE = ISSUE,
        ST_RESP = RESP
    } state_t;
endpackage

// File: rtl/data_mem_arbiter_if.sv
// data_mem_arbiter_if: core/host request ports and the data memory bus
interface data_mem_arbiter_if import data_mem_arbiter_pkg::*; #(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              core_req;
    logic              core_we;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata;
    logic              core_gnt;
    logic              core_rvalid;
    logic [DATA_W-1:0] core_rdata;
    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_gnt;
    logic              host_rvalid;
    logic [DATA_W-1:0] host_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        input  host_req, host_we, host_addr, host_wdata,
        input  mem_rdata,
        output core_gnt, core_rvalid, core_rdata,
        output host_gnt, host_rvalid, host_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );
    modport master (
        output core_req, core_we, core_addr, core_wdata,
        output host_req, host_we, host_addr, host_wdata,
        output mem_rdata,
        input  core_gnt, core_rvalid, core_rdata,
        input  host_gnt, host_rvalid, host_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/data_mem_arbiter_arb_pick.sv
// arb_pick: combinational winner select; MEM_ARB_RR_EN selects round-robin over fixed core priority
module arb_pick import data_mem_arbiter_pkg::*; (
    input  logic [1:0] req,
    input  logic       last_winner,
    output logic       winner,
    output logic       any_req
);
    assign any_req = |req;
`ifdef MEM_ARB_RR_EN
    // a tie goes to the port that did not win last time
    assign winner = &req ? ~last_winner : req[0] ? REQ_CORE : req[1] ? REQ_HOST : last_winner;
`else
    assign winner = req[0] ? REQ_CORE : req[1] ? REQ_HOST : last_winner;
`endif
endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares a single-port sync data memory between core and host ports
// MEM_ARB_RR_EN enables round-robin arbitration (default: fixed core priority)
module data_mem_arbiter import data_mem_arbiter_pkg::*; #(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input logic               clock,
    input logic               reset,
    data_mem_arbiter_if.slave bus
);
    state_t state, state_n;
    logic winner, any_req, last_winner, grant, sel_we, resp_done;
    logic we_q, idx_q, en_q, mem_we_q;
    logic core_gnt_q, host_gnt_q, core_rvalid_q, host_rvalid_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, core_rdata_q, host_rdata_q;

    arb_pick u_pick (
        .req({bus.host_req, bus.core_req}),
        .last_winner(last_winner),
        .winner(winner),
        .any_req(any_req)
    );

    always_ff @(posedge clock) begin
        if (reset) state <= ST_IDLE;
        else state <= state_n;
    end

    always_comb begin
        grant = state == ST_IDLE && any_req;
        resp_done = state == ST_RESP;
        sel_we = winner ? bus.host_we : bus.core_we;
        state_n = grant ? ST_ISSUE : (state == ST_ISSUE && !we_q) ? ST_RESP : ST_IDLE;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            core_gnt_q <= 1'b0;
            host_gnt_q <= 1'b0;
            core_rvalid_q <= 1'b0;
            host_rvalid_q <= 1'b0;
            en_q <= 1'b0;
            mem_we_q <= 1'b0;
            we_q <= 1'b0;
            idx_q <= REQ_CORE;
            addr_q <= '0;
            wdata_q <= '0;
            core_rdata_q <= '0;
            host_rdata_q <= '0;
        end else begin
            core_gnt_q <= grant && winner == REQ_CORE;
            host_gnt_q <= grant && winner == REQ_HOST;
            en_q <= grant;
            mem_we_q <= grant && sel_we;
            core_rvalid_q <= resp_done && idx_q == REQ_CORE;
            host_rvalid_q <= resp_done && idx_q == REQ_HOST;
            if (grant) begin
                idx_q <= winner;
                we_q <= sel_we;
                addr_q <= winner ? bus.host_addr : bus.core_addr;
                wdata_q <= winner ? bus.host_wdata : bus.core_wdata;
            end
            if (resp_done && idx_q == REQ_CORE) core_rdata_q <= bus.mem_rdata;
            if (resp_done && idx_q == REQ_HOST) host_rdata_q <= bus.mem_rdata;
        end
    end

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clock) begin
        if (reset) last_winner <= REQ_HOST;
        else if (grant) last_winner <= winner;
    end
`else
    assign last_winner = REQ_HOST;
`endif

    // strobes are gated by reset so a write in ISSUE is dropped immediately
    assign bus.mem_en = en_q & ~reset;
    assign bus.mem_we = mem_we_q & ~reset;
    assign bus.mem_addr = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.core_gnt = core_gnt_q;
    assign bus.host_gnt = host_gnt_q;
    assign bus.core_rvalid = core_rvalid_q;
    assign bus.host_rvalid = host_rvalid_q;
    assign bus.core_rdata = core_rdata_q;
    assign bus.host_rdata = host_rdata_q;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed and randomized checks of data_mem_arbiter against a transaction-level model
module tb_data_mem_arbiter;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    logic clock = 1'b0;
    logic reset = 1'b1;
    int vectors = 0;
    int miscompares = 0;
    int host_cnt = 0;
    int glog [$];
    logic [15:0] mem [0:255] = '{default: 16'h0};
    logic [15:0] rm [0:255] = '{default: 16'h0};
    bit pend [2];
    bit rwe [2];
    logic [7:0] raddr [2];
    logic [15:0] rwd [2];
    logic [15:0] exp_rd [2];
    logic [15:0] last_rd [2];
    int rv_due [2];

    always #5 clock = ~clock;

    data_mem_arbiter_if #(.ADDR_W(8), .DATA_W(16)) bus ();
    data_mem_arbiter #(.ADDR_W(8), .DATA_W(16)) dut (.clock(clock), .reset(reset), .bus(bus));

    always @(posedge clock) begin
        if (bus.mem_en && bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= mem[bus.mem_addr];
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return 64'({bus.core_gnt, bus.host_gnt, bus.core_rvalid, bus.host_rvalid, bus.mem_en,
                    bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.core_rdata, bus.host_rdata});
    endfunction

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
        chk("gnt_excl", 64'(bus.core_gnt & bus.host_gnt), 64'(0));
        chk("rvalid_excl", 64'(bus.core_rvalid & bus.host_rvalid), 64'(0));
        if (bus.host_gnt || bus.host_rvalid) host_cnt++;
        if (bus.core_gnt) glog.push_back(0);
        if (bus.host_gnt) glog.push_back(1);
    endtask

    task automatic set_req(input bit p, input bit r, input bit we, input logic [7:0] a, input logic [15:0] d);
        if (p) begin
            bus.host_req = r;
            bus.host_we = we;
            bus.host_addr = a;
            bus.host_wdata = d;
        end else begin
            bus.core_req = r;
            bus.core_we = we;
            bus.core_addr = a;
            bus.core_wdata = d;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_req(0, 0, 0, 8'h0, 16'h0);
        set_req(1, 0, 0, 8'h0, 16'h0);
        tick();
        tick();
        chk("reset_outs", outs(), 64'(0));
        reset = 1'b0;
    endtask

    // single uncontended transaction on port p from an idle arbiter
    task automatic txn(input bit p, input bit we, input logic [7:0] a, input logic [15:0] d,
                       input logic [15:0] exp, input string tag);
        set_req(p, 1, we, a, d);
        tick();
        chk({tag, "_gnt"}, 64'(p ? bus.host_gnt : bus.core_gnt), 64'(1));
        chk({tag, "_en"}, 64'({bus.mem_en, bus.mem_we, bus.mem_addr}), 64'({1'b1, we, a}));
        set_req(p, 0, we, a, d);
        tick();
        if (we) begin
            chk({tag, "_commit"}, 64'(mem[a]), 64'(d));
        end else begin
            chk({tag, "_rv_early"}, 64'(p ? bus.host_rvalid : bus.core_rvalid), 64'(0));
            tick();
            chk({tag, "_rv"}, 64'(p ? bus.host_rvalid : bus.core_rvalid), 64'(1));
            chk({tag, "_rdata"}, 64'(p ? bus.host_rdata : bus.core_rdata), 64'(exp));
        end
    endtask

    task automatic new_cmd(input int p);
        pend[p] = 1'b1;
        rwe[p] = 1'($urandom_range(0, 1));
        raddr[p] = 8'(8'h40 + $urandom_range(0, 7));
        rwd[p] = 16'($urandom);
    endtask

    initial begin
        int hc, cg, hg, cv, hv, g0, eg, nf;
        bit last;
        logic [15:0] cd, hd;
        set_req(0, 0, 0, 8'h0, 16'h0);
        set_req(1, 0, 0, 8'h0, 16'h0);
        do_reset();

        hc = host_cnt;
        txn(0, 1, 8'h05, 16'h1234, 16'h0, "core_wr");
        txn(0, 0, 8'h05, 16'h0, 16'h1234, "core_rd");
        chk("host_quiet", 64'(host_cnt - hc), 64'(0));

        txn(0, 1, 8'h01, 16'hAAAA, 16'h0, "pre_wr1");
        txn(0, 1, 8'h02, 16'h5555, 16'h0, "pre_wr2");
        do_reset();
        set_req(0, 1, 0, 8'h01, 16'h0);
        set_req(1, 1, 0, 8'h02, 16'h0);
        cg = -1; hg = -1; cv = -1; hv = -1; cd = 'x; hd = 'x;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (bus.core_gnt && cg < 0) begin cg = c; bus.core_req = 1'b0; end
            if (bus.host_gnt && hg < 0) begin hg = c; bus.host_req = 1'b0; end
            if (bus.core_rvalid && cv < 0) begin cv = c; cd = bus.core_rdata; end
            if (bus.host_rvalid && hv < 0) begin hv = c; hd = bus.host_rdata; end
        end
        chk("tie_core_gnt_cyc", 64'(cg), 64'(1));
        chk("tie_core_rv_cyc", 64'(cv), 64'(3));
        chk("tie_core_rdata", 64'(cd), 64'(16'hAAAA));
        chk("tie_host_gnt_cyc", 64'(hg), 64'(4));
        chk("tie_host_rv_cyc", 64'(hv), 64'(6));
        chk("tie_host_rdata", 64'(hd), 64'(16'h5555));

        do_reset();
        g0 = glog.size();
        set_req(0, 1, 1, 8'h20, 16'hC0C0);
        set_req(1, 1, 1, 8'h21, 16'hB0B0);
        for (int c = 0; c < 60 && glog.size() < g0 + 10; c++) tick();
        set_req(0, 0, 0, 8'h0, 16'h0);
        set_req(1, 0, 0, 8'h0, 16'h0);
        chk("stream_count", 64'(glog.size() >= g0 + 10), 64'(1));
        for (int i = 0; i < 10 && g0 + i < glog.size(); i++)
            chk($sformatf("stream_winner%0d", i), 64'(glog[g0 + i]), 64'(RR ? i % 2 : 0));
        tick();
        tick();

        do_reset();
        set_req(1, 1, 1, 8'h10, 16'hBEEF);
        tick();
        chk("rst_iss_gnt", 64'(bus.host_gnt), 64'(1));
        reset = 1'b1;
        set_req(1, 0, 0, 8'h0, 16'h0);
        #1;
        chk("rst_iss_strobes", 64'({bus.mem_en, bus.mem_we}), 64'(0));
        tick();
        chk("rst_iss_mem", 64'(mem[8'h10]), 64'(0));
        chk("rst_iss_outs", outs(), 64'(0));
        reset = 1'b0;
        txn(0, 0, 8'h10, 16'h0, 16'h0000, "post_iss_rd");

        set_req(0, 1, 0, 8'h01, 16'h0);
        tick();
        chk("rst_resp_gnt", 64'(bus.core_gnt), 64'(1));
        set_req(0, 0, 0, 8'h01, 16'h0);
        tick();
        reset = 1'b1;
        tick();
        chk("rst_resp_rv", 64'({bus.core_rvalid, bus.core_rdata}), 64'(0));
        reset = 1'b0;
        tick();
        chk("rst_resp_rv_late", 64'(bus.core_rvalid), 64'(0));
        txn(0, 0, 8'h01, 16'h0, 16'hAAAA, "post_resp_rd");

        do_reset();
        last = 1'b1;
        nf = 0;
        for (int p = 0; p < 2; p++) begin
            last_rd[p] = 16'h0;
            rv_due[p] = -1;
            if ($urandom_range(0, 99) < 60) new_cmd(p);
            else pend[p] = 1'b0;
            set_req(1'(p), pend[p], rwe[p], raddr[p], rwd[p]);
        end
        for (int t = 1; t <= 400; t++) begin
            tick();
            eg = -1;
            if (t >= nf && (pend[0] || pend[1]))
                eg = (pend[0] && pend[1]) ? (RR ? int'(!last) : 0) : (pend[0] ? 0 : 1);
            chk("rnd_core_gnt", 64'(bus.core_gnt), 64'(eg == 0));
            chk("rnd_host_gnt", 64'(bus.host_gnt), 64'(eg == 1));
            chk("rnd_mem_en", 64'(bus.mem_en), 64'(eg >= 0));
            for (int p = 0; p < 2; p++) begin
                chk($sformatf("rnd_rvalid%0d", p), 64'(p ? bus.host_rvalid : bus.core_rvalid), 64'(rv_due[p] == t));
                if (rv_due[p] == t) last_rd[p] = exp_rd[p];
                chk($sformatf("rnd_rdata%0d", p), 64'(p ? bus.host_rdata : bus.core_rdata), 64'(last_rd[p]));
            end
            if (eg >= 0) begin
                chk("rnd_mem_cmd", 64'({bus.mem_we, bus.mem_addr}), 64'({rwe[eg], raddr[eg]}));
                last = eg[0];
                if (rwe[eg]) begin
                    chk("rnd_mem_wdata", 64'(bus.mem_wdata), 64'(rwd[eg]));
                    rm[raddr[eg]] = rwd[eg];
                    nf = t + 2;
                end else begin
                    exp_rd[eg] = rm[raddr[eg]];
                    rv_due[eg] = t + 2;
                    nf = t + 3;
                end
            end
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] || eg == p) begin
                    if ($urandom_range(0, 99) < 60) new_cmd(p);
                    else pend[p] = 1'b0;
                end
                set_req(1'(p), pend[p], rwe[p], raddr[p], rwd[p]);
            end
        end
        set_req(0, 0, 0, 8'h0, 16'h0);
        set_req(1, 0, 0, 8'h0, 16'h0);
        repeat (4) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
